// File: rtl/posit_encoder_pkg.sv
// Shared constants for the posit encoder stage: FSM encodings, fixed posit
// patterns and parameter derivation helpers.
package posit_encoder_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REGIME = 2'd1;
  localparam logic [1:0] ST_ROUND  = 2'd2;
  localparam logic [1:0] ST_OUT    = 2'd3;

  localparam int MAX_N = 64;
  typedef logic [MAX_N-1:0] pat_t;

  // Patterns are built at MAX_N width; callers size-cast down to N.
  function automatic pat_t nar_pat(input int n);
    return pat_t'(1) << (n - 1);
  endfunction

  function automatic pat_t maxpos_pat(input int n);
    return (pat_t'(1) << (n - 1)) - pat_t'(1);
  endfunction

  function automatic pat_t minpos_pat();
    return pat_t'(1);
  endfunction

  function automatic int fw_of(input int n, input int es);
    return n - es - 3;
  endfunction

  function automatic int sw_of(input int n, input int es);
    return $clog2(n) + es + 2;
  endfunction

endpackage

// File: rtl/posit_encoder_if.sv
// Request/response bundle between the pipeline controller and the encoder.
interface posit_encoder_if #(
  parameter int N  = 32,
  parameter int SW = 9,
  parameter int FW = 27
);
  logic          start;
  logic          zero_in;
  logic          nar_in;
  logic          sign_in;
  logic [SW-1:0] scale_in;
  logic [FW-1:0] frac_in;
  logic          sticky_in;
  logic          busy;
  logic          done;
  logic [N-1:0]  posit_out;

  modport master (
    output start, zero_in, nar_in, sign_in, scale_in, frac_in, sticky_in,
    input  busy, done, posit_out
  );

  modport slave (
    input  start, zero_in, nar_in, sign_in, scale_in, frac_in, sticky_in,
    output busy, done, posit_out
  );
endinterface

// File: rtl/posit_encoder_regime_builder.sv
// Combinational: splits scale into regime k and exponent e, then left-aligns
// {regime, e, frac, sticky} in a 2N-bit body and flags regime saturation.
module posit_regime_builder
  import posit_encoder_pkg::*;
#(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int SW = sw_of(N, ES),
  parameter int FW = fw_of(N, ES)
) (
  input  logic [SW-1:0]  scale_i,
  input  logic [FW-1:0]  frac_i,
  input  logic           sticky_i,
  output logic [2*N-1:0] body_o,
  output logic           sat_max_o,
  output logic           sat_min_o
);
  localparam int BW = 2 * N;
  localparam int TW = ES + FW + 1;
  localparam int KW = SW - ES;

  logic signed [KW-1:0] k;
  logic [BW-1:0]        tail_al;
  logic [BW-1:0]        prefix;
  logic [7:0]           pamt;
  logic [7:0]           rlen;
  int                   kc;

  assign k       = scale_i[SW-1:ES];
  assign tail_al = {scale_i[ES-1:0], frac_i, sticky_i, {(BW-TW){1'b0}}};

  always_comb begin
    kc        = int'(k);
    sat_max_o = (kc > N - 2);
    sat_min_o = (kc < -(N - 2));
    // Clamp so the shift amounts stay in range; saturation overrides the body.
    if (sat_max_o)      kc = N - 2;
    else if (sat_min_o) kc = -(N - 2);
    if (kc >= 0) begin
      pamt   = 8'(kc + 1);
      rlen   = 8'(kc + 2);
      prefix = ~({BW{1'b1}} >> pamt);
    end else begin
      pamt   = 8'(-kc);
      rlen   = 8'(1 - kc);
      prefix = {1'b1, {(BW-1){1'b0}}} >> pamt;
    end
    body_o = prefix | (tail_al >> rlen);
  end

endmodule

// File: rtl/posit_encoder.sv
// Posit pack stage: registers operands, builds the regime body, rounds to
// nearest-even with saturation, and emits the two's-complement posit.
module posit_encoder
  import posit_encoder_pkg::*;
#(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int SW = sw_of(N, ES),
  parameter int FW = fw_of(N, ES)
) (
  input logic           clk,
  input logic           rst,
  posit_encoder_if.slave enc
);
  localparam int BW = 2 * N;
  localparam logic [N-1:0] NAR    = N'(nar_pat(N));
  localparam logic [N-1:0] MAXPOS = N'(maxpos_pat(N));
  localparam logic [N-1:0] MINPOS = N'(minpos_pat());

  logic [1:0]    state_q, state_d;
  logic          zero_q, zero_d, nar_q, nar_d, sign_q, sign_d, sticky_q, sticky_d;
  logic [SW-1:0] scale_q, scale_d;
  logic [FW-1:0] frac_q, frac_d;
  logic [BW-1:0] body_q, body_d;
  logic          sat_max_q, sat_max_d, sat_min_q, sat_min_d;
  logic [N-1:0]  mag_q, mag_d;
  logic [N-1:0]  posit_q, posit_d;
  logic          done_q, done_d;

  logic [BW-1:0] body_w;
  logic          sat_max_w, sat_min_w;
  logic [N-2:0]  keep;
  logic          guard, rest, inc;
  logic [N-1:0]  sum;

  posit_regime_builder #(.N(N), .ES(ES), .SW(SW), .FW(FW)) u_regime (
    .scale_i   (scale_q),
    .frac_i    (frac_q),
    .sticky_i  (sticky_q),
    .body_o    (body_w),
    .sat_max_o (sat_max_w),
    .sat_min_o (sat_min_w)
  );

  assign keep  = body_q[BW-1 -: N-1];
  assign guard = body_q[BW-N];
  assign rest  = (|body_q[BW-N-1:0]) | sticky_q;
  assign inc   = guard & (rest | keep[0]);
  assign sum   = {1'b0, keep} + N'(inc);

  always_comb begin
    state_d   = state_q;
    zero_d    = zero_q;
    nar_d     = nar_q;
    sign_d    = sign_q;
    sticky_d  = sticky_q;
    scale_d   = scale_q;
    frac_d    = frac_q;
    body_d    = body_q;
    sat_max_d = sat_max_q;
    sat_min_d = sat_min_q;
    mag_d     = mag_q;
    posit_d   = posit_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A start coinciding with the done pulse is dropped, not accepted.
        if (enc.start && !done_q) begin
          zero_d   = enc.zero_in;
          nar_d    = enc.nar_in;
          sign_d   = enc.sign_in;
          scale_d  = enc.scale_in;
          frac_d   = enc.frac_in;
          sticky_d = enc.sticky_in;
          state_d  = ST_REGIME;
        end
      end
      ST_REGIME: begin
        body_d    = body_w;
        sat_max_d = sat_max_w;
        sat_min_d = sat_min_w;
        state_d   = ST_ROUND;
      end
      ST_ROUND: begin
        if (sat_max_q)      mag_d = MAXPOS;
        else if (sat_min_q) mag_d = MINPOS;
        else if (sum[N-1])  mag_d = MAXPOS;
        else if (sum == '0) mag_d = MINPOS;
        else                mag_d = sum;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (nar_q)       posit_d = NAR;
        else if (zero_q) posit_d = '0;
        else if (sign_q) posit_d = -mag_q;
        else             posit_d = mag_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      zero_q    <= 1'b0;
      nar_q     <= 1'b0;
      sign_q    <= 1'b0;
      sticky_q  <= 1'b0;
      scale_q   <= '0;
      frac_q    <= '0;
      body_q    <= '0;
      sat_max_q <= 1'b0;
      sat_min_q <= 1'b0;
      mag_q     <= '0;
      posit_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      zero_q    <= zero_d;
      nar_q     <= nar_d;
      sign_q    <= sign_d;
      sticky_q  <= sticky_d;
      scale_q   <= scale_d;
      frac_q    <= frac_d;
      body_q    <= body_d;
      sat_max_q <= sat_max_d;
      sat_min_q <= sat_min_d;
      mag_q     <= mag_d;
      posit_q   <= posit_d;
      done_q    <= done_d;
    end
  end

  assign enc.busy      = (state_q != ST_IDLE);
  assign enc.done      = done_q;
  assign enc.posit_out = posit_q;

endmodule

// File: tb/tb_posit_encoder.sv
// Scoreboard bench for posit_encoder (N=32, ES=2): directed and random
// operations checked against a bit-list reference encoder.
module tb_posit_encoder;
  localparam int N  = 32;
  localparam int ES = 2;
  localparam int SW = 9;
  localparam int FW = 27;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  posit_encoder_if #(.N(N), .SW(SW), .FW(FW)) enc ();

  posit_encoder #(.N(N), .ES(ES), .SW(SW), .FW(FW)) dut (
    .clk (clk),
    .rst (rst),
    .enc (enc)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    bit          z;
    bit          nr;
    bit          s;
    int          sc;
    logic [26:0] f;
    bit          st;
    logic [31:0] ex;
  } vec_t;

  vec_t vecs[13] = '{
    '{0, 0, 0,    0, 27'h0, 0, 32'h4000_0000},
    '{0, 0, 0,   -1, 27'h0, 0, 32'h3800_0000},
    '{0, 0, 1,    0, 27'h0, 0, 32'hC000_0000},
    '{0, 0, 0,    4, 27'h1, 0, 32'h6000_0000},
    '{0, 0, 0,    4, 27'h3, 0, 32'h6000_0002},
    '{0, 0, 0,    4, 27'h1, 1, 32'h6000_0001},
    '{0, 0, 0,  200, 27'h0, 0, 32'h7FFF_FFFF},
    '{0, 0, 0, -200, 27'h0, 0, 32'h0000_0001},
    '{0, 0, 1,  200, 27'h5, 0, 32'h8000_0001},
    '{0, 0, 1, -200, 27'h0, 0, 32'hFFFF_FFFF},
    '{0, 1, 1,   37, 27'h9, 1, 32'h8000_0000},
    '{1, 0, 1,   12, 27'h7, 0, 32'h0000_0000},
    '{1, 1, 0,    3, 27'h0, 0, 32'h8000_0000}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: lay out regime/exponent/fraction/sticky as a bit list, cut at N-1.
  function automatic logic [31:0] ref_enc(input bit z, input bit nr, input bit s,
                                          input int sc, input logic [26:0] f, input bit st);
    int     e;
    int     k;
    bit     q[$];
    longint keep;
    longint m;
    bit     g;
    bit     rest;
    if (nr) return 32'h8000_0000;
    if (z) return 32'h0;
    e = sc & 3;
    k = (sc - e) / 4;
    if (k > 30) m = 64'h7FFF_FFFF;
    else if (k < -30) m = 1;
    else begin
      if (k >= 0) begin
        repeat (k + 1) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        repeat (-k) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      q.push_back(e[1]);
      q.push_back(e[0]);
      for (int i = 26; i >= 0; i--) q.push_back(f[i]);
      q.push_back(st);
      keep = 0;
      for (int i = 0; i < 31; i++) keep = keep * 2 + longint'(q[i]);
      g    = q[31];
      rest = st;
      for (int i = 32; i < q.size(); i++) rest = rest | q[i];
      m = keep + ((g && (rest || (keep % 2 == 1))) ? 1 : 0);
      if (m >= 64'h8000_0000) m = 64'h7FFF_FFFF;
      if (m == 0) m = 1;
    end
    return s ? 32'(-m) : 32'(m);
  endfunction

  always @(negedge clk) begin
    if (!rst && enc.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with no pending result, required done=0");
      end else begin
        check("posit_out", enc.posit_out, exp_q.pop_front());
      end
    end
  end

  task automatic do_op(input string name, input bit z, input bit nr, input bit s,
                       input int sc, input logic [26:0] f, input bit st,
                       input logic [31:0] expv, input bit repulse);
    int cnt;
    bit seen;
    @(negedge clk);
    enc.zero_in   = z;
    enc.nar_in    = nr;
    enc.sign_in   = s;
    enc.scale_in  = 9'(sc);
    enc.frac_in   = f;
    enc.sticky_in = st;
    enc.start     = 1'b1;
    exp_q.push_back(expv);
    cnt  = 0;
    seen = 0;
    while (!seen && cnt < 10) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) check({name, "_busy"}, 32'(enc.busy), 32'd1);
      if (repulse) begin
        enc.start    = 1'b1;
        enc.nar_in   = ~nr;
        enc.scale_in = 9'($urandom);
      end else begin
        enc.start = 1'b0;
      end
      seen = enc.done;
    end
    check({name, "_latency"}, 32'(cnt), 32'd4);
    @(negedge clk);
    enc.start  = 1'b0;
    enc.nar_in = 1'b0;
    check({name, "_done_width"}, 32'(enc.done), 32'd0);
    check({name, "_idle_after"}, 32'(enc.busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          got_done;
    bit          z, nr, s, st;
    int          sc;
    logic [26:0] f;

    rst           = 1'b1;
    enc.start     = 1'b0;
    enc.zero_in   = 1'b0;
    enc.nar_in    = 1'b0;
    enc.sign_in   = 1'b0;
    enc.scale_in  = '0;
    enc.frac_in   = '0;
    enc.sticky_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(enc.busy), 32'd0);
    check("rst_done", 32'(enc.done), 32'd0);
    check("rst_posit", enc.posit_out, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      do_op($sformatf("vec%0d", i), vecs[i].z, vecs[i].nr, vecs[i].s,
            vecs[i].sc, vecs[i].f, vecs[i].st, vecs[i].ex, 1'b0);

    do_op("repulse", 0, 0, 0, 0, 27'h0, 0, 32'h4000_0000, 1'b1);
    got_done = 0;
    repeat (6) begin
      @(negedge clk);
      got_done = got_done | enc.done;
    end
    check("repulse_single_done", 32'(got_done), 32'd0);

    do_op("pre_abort", 0, 0, 0, -1, 27'h0, 0, 32'h3800_0000, 1'b0);
    @(negedge clk);
    enc.scale_in = 9'd4;
    enc.frac_in  = 27'h3;
    enc.start    = 1'b1;
    @(negedge clk);
    enc.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(enc.busy), 32'd0);
    check("abort_posit", enc.posit_out, 32'd0);
    got_done = 0;
    repeat (6) begin
      @(negedge clk);
      got_done = got_done | enc.done;
    end
    check("abort_no_done", 32'(got_done), 32'd0);

    @(negedge clk);
    rst       = 1'b1;
    enc.start = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    enc.start = 1'b0;
    check("rst_beats_start", 32'(enc.busy), 32'd0);

    do_op("post_abort", 0, 0, 0, 0, 27'h0, 0, 32'h4000_0000, 1'b0);

    for (int i = 0; i < 200; i++) begin
      z  = ($urandom_range(0, 15) == 0);
      nr = ($urandom_range(0, 15) == 0);
      s  = 1'($urandom);
      st = 1'($urandom);
      f  = 27'($urandom);
      if ($urandom_range(0, 3) == 0) sc = int'($urandom_range(0, 511)) - 256;
      else                           sc = int'($urandom_range(0, 260)) - 130;
      do_op($sformatf("rnd%0d", i), z, nr, s, sc, f, st, ref_enc(z, nr, s, sc, f, st), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
